// File: rtl/count_pkg.sv
// count_pkg: shared state encoding and width default for count_ctrl
package count_pkg;
  localparam int WIDTH_DEF = 6;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;
endpackage

// File: rtl/count_ctrl.sv
// count_ctrl: grants a bounded number of increments to an external free-running counter
module count_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] elapsed
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] base, lim, held, diff;
  logic             go;
  // modular difference keeps elapsed correct across counter wrap
  assign diff    = q - base;
  assign go      = (state == IDLE) && start && !stop;
  assign busy    = state == RUN;
  assign done    = state == DONE;
  assign aborted = state == ABORT;
  assign elapsed = busy ? diff : held;
  assign en      = busy && !stop && (diff != lim);
  always_comb begin
    state_nxt = (state == IDLE) ? (go ? RUN : IDLE) :
                (state == RUN)  ? (stop ? ABORT : ((diff == lim) ? DONE : RUN)) :
                IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      lim   <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        base <= q;
        lim  <= limit;
      end
      if (busy) held <= diff;
    end
  end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: scoreboard bench driving count_ctrl against a modelled downstream counter
module tb_count_ctrl;
  typedef struct {
    logic       kind;
    logic [5:0] el;
    logic [5:0] qf;
    int         cyc;
  } exp_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       stop = 0;
  logic [5:0] limit = 0;
  logic [5:0] q = 0;
  logic [5:0] q_set = 0;
  logic       q_load = 0;
  logic       en, busy, done, aborted;
  logic [5:0] elapsed;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         en_cnt = 0;
  exp_t       sb[$];

  count_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .limit(limit),
    .q(q), .en(en), .busy(busy), .done(done), .aborted(aborted), .elapsed(elapsed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) q <= q_load ? q_set : q + {5'd0, en};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) en_cnt = 0;
    else begin
      if (en) en_cnt++;
      if (done || aborted) begin
        check("pulse_exclusive", int'(done && aborted), 0);
        if (sb.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = sb.pop_front();
          check("pulse_kind", int'(done), int'(e.kind));
          check("final_elapsed", int'(elapsed), int'(e.el));
          check("final_q", int'(q), int'(e.qf));
          check("en_cycles", en_cnt, int'(e.el));
          check("pulse_cycle", cyc, e.cyc);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic launch(input logic [5:0] q0, input logic [5:0] lim, output int sc);
    q_set  = q0;
    q_load = 1;
    step();
    q_load = 0;
    start  = 1;
    limit  = lim;
    sc     = cyc;
    step();
    start  = 0;
  endtask

  task automatic push(input logic kind, input logic [5:0] el, input logic [5:0] qf, input int c);
    exp_t e;
    e.kind = kind;
    e.el   = el;
    e.qf   = qf;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_elapsed(input logic [5:0] v);
    int n = 0;
    while (elapsed != v && n < 100) begin
      step();
      n++;
    end
    if (n == 100) check("timeout_elapsed", int'(elapsed), int'(v));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("sb_drain", sb.size(), 0);
    step();
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"}, int'(en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_aborted"}, int'(aborted), 0);
    check({tag, "_elapsed"}, int'(elapsed), 0);
  endtask

  initial begin
    int sc;
    step();
    step();
    check_zero("reset");
    rst_n = 1;
    step();

    // basic 3-step run
    launch(6'd5, 6'd3, sc);
    push(1'b1, 6'd3, 6'd8, sc + 5);
    check("run_busy", int'(busy), 1);
    check("run_en", int'(en), 1);
    drain();

    // wrap run with a start pulse mid-run that must be ignored
    launch(6'd60, 6'd10, sc);
    push(1'b1, 6'd10, 6'd6, sc + 12);
    step();
    step();
    step();
    start = 1;
    limit = 6'd2;
    #1;
    check("ignored_start_elapsed", int'(elapsed), 3);
    step();
    start = 0;
    check("ignored_start_elapsed_after", int'(elapsed), 4);
    drain();
    check("held_elapsed_idle", int'(elapsed), 10);

    // stop after 7 increments
    launch(6'd0, 6'd20, sc);
    push(1'b0, 6'd7, 6'd7, sc + 9);
    wait_elapsed(6'd7);
    stop = 1;
    #1;
    check("en_stop_cycle", int'(en), 0);
    step();
    stop = 0;
    drain();

    // zero-limit run
    launch(6'd33, 6'd0, sc);
    push(1'b1, 6'd0, 6'd33, sc + 2);
    check("zero_lim_en", int'(en), 0);
    check("zero_lim_busy", int'(busy), 1);
    drain();

    // start and stop together stay idle
    start = 1;
    stop  = 1;
    limit = 6'd5;
    step();
    start = 0;
    stop  = 0;
    check("start_stop_busy", int'(busy), 0);
    check("start_stop_en", int'(en), 0);
    step();
    check("start_stop_busy2", int'(busy), 0);

    // reset mid-run, then a normal run
    launch(6'd10, 6'd8, sc);
    wait_elapsed(6'd4);
    rst_n = 0;
    #1;
    check_zero("midreset");
    check("midreset_q", int'(q), 14);
    step();
    step();
    check("midreset_q_hold", int'(q), 14);
    rst_n = 1;
    step();
    launch(6'd20, 6'd5, sc);
    push(1'b1, 6'd5, 6'd25, sc + 7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
